// File: rtl/aud_ctrl_fsm_pkg.sv
// Shared types for the audio record/play controller: state encoding, key indices, speed type.
package aud_ctrl_pkg;

   typedef enum logic [2:0] {
      S_IDLE       = 3'd0,
      S_I2C        = 3'd1,
      S_RECD       = 3'd2,
      S_RECD_PAUSE = 3'd3,
      S_PLAY       = 3'd4,
      S_PLAY_PAUSE = 3'd5,
      S_STOP       = 3'd6
   } state_t;

   localparam int KEY_PLAY = 0;
   localparam int KEY_REC  = 1;
   localparam int KEY_STOP = 2;
   localparam int NUM_KEYS = 3;

   typedef logic [2:0] speed_t;

   // Returns {fast, slow_0, slow_1}; a speed factor of 1 means normal play, so no mode applies.
   function automatic logic [2:0] modeFlags(input logic fast, input logic interp, input speed_t speed);
      if (speed == 3'd0) begin
         return 3'b000;
      end
      return {fast, ~fast & ~interp, ~fast & interp};
   endfunction

endpackage

// File: rtl/aud_ctrl_fsm_if.sv
// Command/status bundle between the controller (master) and the recorder/DSP side (slave).
interface aud_ctrl_fsm_if #(
   parameter int ADDR_W = 20
);
   logic [ADDR_W-1:0] i_rec_addr;
   logic [ADDR_W-1:0] i_play_addr;
   logic              o_rec_start;
   logic              o_rec_pause;
   logic              o_rec_stop;
   logic              o_dsp_start;
   logic              o_dsp_pause;
   logic              o_dsp_stop;
   logic [ADDR_W-1:0] o_end_addr;
   logic              o_sram_wr_sel;

   modport master (
      input  i_rec_addr, i_play_addr,
      output o_rec_start, o_rec_pause, o_rec_stop,
      output o_dsp_start, o_dsp_pause, o_dsp_stop,
      output o_end_addr, o_sram_wr_sel
   );

   modport slave (
      output i_rec_addr, i_play_addr,
      input  o_rec_start, o_rec_pause, o_rec_stop,
      input  o_dsp_start, o_dsp_pause, o_dsp_stop,
      input  o_end_addr, o_sram_wr_sel
   );
endinterface

// File: rtl/aud_ctrl_fsm_key_debounce.sv
// One active-low key: 2-flop synchroniser, stable-count debouncer and press-edge detector.
module key_debounce #(
   parameter int DEB_CYC = 20000
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_key_n,
   output logic o_press
);

   localparam int CNT_W = $clog2(DEB_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYC - 1);

   logic [1:0]       r_sync;
   logic             r_stable;
   logic [CNT_W-1:0] r_cnt;
   logic             r_press;

   // A new level is accepted only after DEB_CYC consecutive matching samples; a 1->0 acceptance is a press.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_sync   <= 2'b11;
         r_stable <= 1'b1;
         r_cnt    <= '0;
         r_press  <= 1'b0;
      end else begin
         r_sync  <= {r_sync[0], i_key_n};
         r_press <= 1'b0;
         if (r_sync[1] != r_stable) begin
            if (r_cnt == CNT_LAST) begin
               r_stable <= r_sync[1];
               r_cnt    <= '0;
               r_press  <= r_stable;
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            r_cnt <= '0;
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/aud_ctrl_fsm.sv
// Record/play controller: key commands, codec init sequencing, end-address tracking.
// Optional second counters enabled by defining AUD_CTRL_TIMER_EN.
module aud_ctrl_fsm
   import aud_ctrl_pkg::*;
#(
   parameter int                ADDR_W   = 20,
   parameter int                DEB_CYC  = 20000,
   parameter logic [ADDR_W-1:0] ADDR_MAX = {ADDR_W{1'b1}}
`ifdef AUD_CTRL_TIMER_EN
   , parameter int              CLK_HZ   = 12000000
`endif
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic                  i_key_0,
   input  logic                  i_key_1,
   input  logic                  i_key_2,
   input  speed_t                i_speed,
   input  logic                  i_fast,
   input  logic                  i_interp,
   input  logic                  i_i2c_finished,
   output logic                  o_i2c_start,
   output logic                  o_fast,
   output logic                  o_slow_0,
   output logic                  o_slow_1,
   output speed_t                o_speed,
   output logic [2:0]            o_state,
`ifdef AUD_CTRL_TIMER_EN
   output logic [5:0]            o_rec_sec,
   output logic [5:0]            o_play_sec,
`endif
   aud_ctrl_fsm_if.master        io_bus
);

   logic [NUM_KEYS-1:0] w_keyN;
   logic [NUM_KEYS-1:0] w_press;
   logic                w_evStop;
   logic                w_evRec;
   logic                w_evPlay;

   assign w_keyN = {i_key_2, i_key_1, i_key_0};

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      key_debounce #(.DEB_CYC(DEB_CYC)) u_key (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_key_n (w_keyN[k]),
         .o_press (w_press[k])
      );
   end

   // Stop wins over record, record over play.
   assign w_evStop = w_press[KEY_STOP];
   assign w_evRec  = w_press[KEY_REC] & ~w_evStop;
   assign w_evPlay = w_press[KEY_PLAY] & ~w_press[KEY_REC] & ~w_evStop;

   state_t            r_state;
   logic              r_i2cStart;
   logic              r_recStart, r_recPause, r_recStop;
   logic              r_dspStart, r_dspPause, r_dspStop;
   logic              r_fast, r_slow0, r_slow1;
   speed_t            r_speed;
   logic [ADDR_W-1:0] r_endAddr;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_i2cStart <= 1'b0;
         r_recStart <= 1'b0;
         r_recPause <= 1'b0;
         r_recStop  <= 1'b0;
         r_dspStart <= 1'b0;
         r_dspPause <= 1'b0;
         r_dspStop  <= 1'b0;
         r_fast     <= 1'b0;
         r_slow0    <= 1'b0;
         r_slow1    <= 1'b0;
         r_speed    <= '0;
         r_endAddr  <= '0;
      end else begin
         r_i2cStart <= 1'b0;
         r_recStart <= 1'b0;
         r_recPause <= 1'b0;
         r_recStop  <= 1'b0;
         r_dspStart <= 1'b0;
         r_dspPause <= 1'b0;
         r_dspStop  <= 1'b0;

         // Playback mode may only change while stopped or paused, never mid-stream.
         if (r_state == S_STOP || r_state == S_PLAY_PAUSE) begin
            {r_fast, r_slow0, r_slow1} <= modeFlags(i_fast, i_interp, i_speed);
            r_speed <= i_speed;
         end

         case (r_state)
            S_IDLE: begin
               r_i2cStart <= 1'b1;
               r_state    <= S_I2C;
            end
            S_I2C: begin
               if (i_i2c_finished) r_state <= S_STOP;
            end
            S_STOP: begin
               if (w_evRec) begin
                  r_recStart <= 1'b1;
                  r_state    <= S_RECD;
               end else if (w_evPlay && r_endAddr != '0) begin
                  r_dspStart <= 1'b1;
                  r_state    <= S_PLAY;
               end
            end
            S_RECD: begin
               if (w_evStop || io_bus.i_rec_addr == ADDR_MAX) begin
                  r_recStop <= 1'b1;
                  r_endAddr <= io_bus.i_rec_addr;
                  r_state   <= S_STOP;
               end else if (w_evRec) begin
                  r_recPause <= 1'b1;
                  r_state    <= S_RECD_PAUSE;
               end
            end
            S_RECD_PAUSE: begin
               if (w_evStop) begin
                  r_recStop <= 1'b1;
                  r_endAddr <= io_bus.i_rec_addr;
                  r_state   <= S_STOP;
               end else if (w_evRec) begin
                  r_recStart <= 1'b1;
                  r_state    <= S_RECD;
               end
            end
            S_PLAY: begin
               if (w_evStop || io_bus.i_play_addr >= r_endAddr) begin
                  r_dspStop <= 1'b1;
                  r_state   <= S_STOP;
               end else if (w_evPlay) begin
                  r_dspPause <= 1'b1;
                  r_state    <= S_PLAY_PAUSE;
               end
            end
            S_PLAY_PAUSE: begin
               if (w_evStop) begin
                  r_dspStop <= 1'b1;
                  r_state   <= S_STOP;
               end else if (w_evPlay) begin
                  r_dspStart <= 1'b1;
                  r_state    <= S_PLAY;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

`ifdef AUD_CTRL_TIMER_EN
   localparam int TICK_W = $clog2(CLK_HZ + 1);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLK_HZ - 1);

   logic [TICK_W-1:0] r_tick;
   logic [5:0]        r_recSec;
   logic [5:0]        r_playSec;

   // One shared sub-second tick: record and play are never active together, and pauses keep the fraction.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_tick    <= '0;
         r_recSec  <= '0;
         r_playSec <= '0;
      end else if (r_state == S_STOP && w_evRec) begin
         r_tick   <= '0;
         r_recSec <= '0;
      end else if (r_state == S_STOP && w_evPlay && r_endAddr != '0) begin
         r_tick    <= '0;
         r_playSec <= '0;
      end else if (r_state == S_RECD || r_state == S_PLAY) begin
         if (r_tick == TICK_LAST) begin
            r_tick <= '0;
            if (r_state == S_RECD && r_recSec != 6'd63) r_recSec <= r_recSec + 1'b1;
            if (r_state == S_PLAY && r_playSec != 6'd63) r_playSec <= r_playSec + 1'b1;
         end else begin
            r_tick <= r_tick + 1'b1;
         end
      end
   end

   assign o_rec_sec  = r_recSec;
   assign o_play_sec = r_playSec;
`endif

   assign o_i2c_start          = r_i2cStart;
   assign o_fast               = r_fast;
   assign o_slow_0             = r_slow0;
   assign o_slow_1             = r_slow1;
   assign o_speed              = r_speed;
   assign o_state              = r_state;
   assign io_bus.o_rec_start   = r_recStart;
   assign io_bus.o_rec_pause   = r_recPause;
   assign io_bus.o_rec_stop    = r_recStop;
   assign io_bus.o_dsp_start   = r_dspStart;
   assign io_bus.o_dsp_pause   = r_dspPause;
   assign io_bus.o_dsp_stop    = r_dspStop;
   assign io_bus.o_end_addr    = r_endAddr;
   assign io_bus.o_sram_wr_sel = (r_state == S_RECD);

endmodule

// File: doc/aud_ctrl_fsm.md
Name: aud_ctrl_fsm

Overview:
Top-level record/play controller for the audio path.
- Turns the three user keys into single-cycle start/pause/stop commands for the recorder and the DSP/player chain.
- Sequences WM8731 I2C initialisation after reset.
- Latches the end-of-recording address and stops playback when it is reached.
- Sits upstream of the recorder and DSP; drives the SRAM-ownership select used by the top level.

Parameters:
ADDR_W, 20, SRAM word address width.
DEB_CYC, 20000, cycles a raw key level must be stable before it is accepted.
ADDR_MAX, 20'hFFFFF, last writable SRAM address; recording auto-stops here.

Ports:
i_clk  in  1  system clock (same domain as recorder/DSP control)
i_rst  in  1  synchronous, active-high reset
i_key_0  in  1  raw key, active-low: play / pause-resume
i_key_1  in  1  raw key, active-low: record / pause-resume
i_key_2  in  1  raw key, active-low: stop
i_speed  in  3  speed selector, 0..7 means factor 1..8
i_fast  in  1  1 = fast play; overrides slow modes
i_interp  in  1  slow mode: 0 = constant, 1 = linear interpolation
i_i2c_finished  in  1  level, high once codec initialisation is done
i_rec_addr  in  ADDR_W  current recorder write address
i_play_addr  in  ADDR_W  current DSP read address
o_i2c_start  out  1  one-cycle pulse
o_rec_start, o_rec_pause, o_rec_stop  out  1 each  one-cycle pulses
o_dsp_start, o_dsp_pause, o_dsp_stop  out  1 each  one-cycle pulses
o_fast, o_slow_0, o_slow_1  out  1 each  registered, mutually exclusive mode flags
o_speed  out  3  registered copy of i_speed
o_end_addr  out  ADDR_W  last recorded address
o_sram_wr_sel  out  1  1 while in S_RECD
o_state  out  3  current state encoding

Behaviour:
- Reset values: state S_IDLE, all pulses 0, mode flags 0, o_speed 0, o_end_addr 0, o_sram_wr_sel 0. Debouncers are cleared to "released".
- Key path: each key goes through a 2-flop synchroniser, then a stable-count debouncer (DEB_CYC), then a press-edge detector. A press yields exactly one 1-cycle event. Latency from stable level to event is DEB_CYC+3 cycles.
- Simultaneous events in one cycle: stop > record > play; lower-priority events that cycle are dropped.
- States and transitions:
  - S_IDLE: the cycle after reset, pulse o_i2c_start and go to S_I2C.
  - S_I2C: wait for i_i2c_finished=1, then go to S_STOP. All keys ignored.
  - S_STOP: key_1 → o_rec_start, S_RECD. key_0 with o_end_addr≠0 → o_dsp_start, S_PLAY. key_0 with o_end_addr=0 is ignored.
  - S_RECD: key_1 → o_rec_pause, S_RECD_PAUSE. key_2, or i_rec_addr==ADDR_MAX → o_rec_stop, latch o_end_addr=i_rec_addr, S_STOP.
  - S_RECD_PAUSE: key_1 → o_rec_start, S_RECD. key_2 → o_rec_stop, latch end address, S_STOP.
  - S_PLAY: key_0 → o_dsp_pause, S_PLAY_PAUSE. key_2, or i_play_addr ≥ o_end_addr → o_dsp_stop, S_STOP.
  - S_PLAY_PAUSE: key_0 → o_dsp_start, S_PLAY. key_2 → o_dsp_stop, S_STOP.
- Any key not listed for the current state is ignored.
- Mode flags and o_speed update only in S_STOP and S_PLAY_PAUSE; they are frozen elsewhere.
  - o_fast = i_fast.
  - o_slow_0 = !i_fast & !i_interp.
  - o_slow_1 = !i_fast & i_interp.
  - Exception: speed factor 1 (i_speed=0) forces all three flags to 0.
- A new recording overwrites o_end_addr on stop. Pausing never changes it.
- Reset mid-operation: returns to S_IDLE and I2C init is re-run. No stop pulse is emitted.
- State encoding: S_IDLE=0, S_I2C=1, S_RECD=2, S_RECD_PAUSE=3, S_PLAY=4, S_PLAY_PAUSE=5, S_STOP=6.

Optional Feature:
AUD_CTRL_TIMER_EN.
- When defined: adds parameter CLK_HZ (default 12000000) and outputs o_rec_sec[5:0] and o_play_sec[5:0].
  - Each output counts whole seconds while its active state (S_RECD / S_PLAY) is held, saturating at 63.
  - The count holds during pause.
  - o_rec_sec clears on each new record start from S_STOP; o_play_sec clears on each play start from S_STOP.
- When undefined: the ports and counters are absent.

Decomposition:
- Package aud_ctrl_pkg holds:
  - the state enum typedef with the encodings above;
  - key index constants (KEY_PLAY=0, KEY_REC=1, KEY_STOP=2);
  - the speed typedef (3 bits).
- One sub-module, key_debounce: synchroniser, debouncer and edge detector. It is instantiated 3 times.

Test Plan:
- Reset, then i_i2c_finished raised 10 cycles later → one o_i2c_start pulse at cycle 1; state 1 → 6 on the cycle after finished.
- Record: key_1 press, then key_2 press when i_rec_addr=0x00123 → o_rec_start and o_rec_stop one cycle each; o_end_addr=0x00123; state returns to 6.
- Play: i_speed=3, i_fast=0, i_interp=1, key_0 press → o_dsp_start; o_slow_1=1, o_speed=3. Drive i_play_addr to 0x00123 → one o_dsp_stop pulse, state 6.
- Keys 1 and 2 released-to-pressed in the same cycle while in S_RECD → only o_rec_stop asserted.
- Key glitch of DEB_CYC-1 cycles → no event. Press held 5×DEB_CYC → exactly one event.
- i_rec_addr reaches ADDR_MAX during S_RECD → auto o_rec_stop, o_end_addr=ADDR_MAX.
